// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cacheline memory-port arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    GAP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } arb_client_t;

  // Gap counter width: enough to hold GAP_CYCLES-1, never narrower than one bit.
  function automatic int unsigned gap_cnt_width(input int unsigned gap_cycles);
    int unsigned w;
    w = $clog2(gap_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache and D-cache
// miss controllers, with a programmable idle gap between consecutive grants.
module cache_line_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic [LINE_WIDTH-1:0] i_mem_wdata,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,

  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int unsigned GapW = gap_cnt_width(GAP_CYCLES);
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;
  localparam arb_state_t ReleaseState = (GAP_CYCLES > 0) ? GAP : IDLE;

  arb_state_t  state_q, state_d;
  arb_client_t last_grant_q, last_grant_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic        i_pend, d_pend;
  arb_client_t pick;

  assign i_pend = i_mem_read | i_mem_write;
  assign d_pend = d_mem_read | d_mem_write;

  // On a tie the client that did not win last time goes first.
  assign pick = (i_pend && d_pend) ? ((last_grant_q == CLIENT_I) ? CLIENT_D : CLIENT_I)
                                   : (d_pend ? CLIENT_D : CLIENT_I);

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= CLIENT_I;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          last_grant_d = pick;
          state_d      = (pick == CLIENT_D) ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I: begin
        // Completion and abandon both release the port the same way.
        if (mem_resp || !i_pend) begin
          state_d   = ReleaseState;
          gap_cnt_d = GapLoad;
        end
      end
      GRANT_D: begin
        if (mem_resp || !d_pend) begin
          state_d   = ReleaseState;
          gap_cnt_d = GapLoad;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_mem_resp  = 1'b0;
    d_mem_resp  = 1'b0;
    unique case (state_q)
      GRANT_I: begin
        mem_read    = i_mem_read & ~i_mem_write;
        mem_write   = i_mem_write;
        mem_address = i_mem_address;
        mem_wdata   = i_mem_wdata;
        i_mem_resp  = mem_resp;
      end
      GRANT_D: begin
        mem_read    = d_mem_read & ~d_mem_write;
        mem_write   = d_mem_write;
        mem_address = d_mem_address;
        mem_wdata   = d_mem_wdata;
        d_mem_resp  = mem_resp;
      end
      default: ;
    endcase
  end

endmodule
